// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and queue entry type for the fetch stage
package fetch_pkg;

  localparam int FETCH_WIDTH = 32;

  // addi x0, x0, 0 -- shown on the ID interface whenever nothing is valid
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0] pc;
    logic [FETCH_WIDTH-1:0] pc_4;
    logic [FETCH_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular prefetch FIFO of fetch entries with flush
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic          valid,
  output logic [CW-1:0] count
);

  fetch_entry_t  entries [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  // A pop needs something to remove; a push needs a free slot, which a
  // simultaneous pop provides even when the queue is full.
  always_comb begin
    pop_ok  = pop && (count != '0);
    push_ok = push && ((count != CW'(DEPTH)) || pop_ok);
  end

  assign head  = entries[rd_ptr];
  assign valid = (count != '0);

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      entries[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - PC generator, instruction memory and prefetch queue
module instruction_fetch_queue
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               SIZE     = 256,
  parameter int               QDEPTH   = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  localparam int              LOGSIZE  = $clog2(SIZE),
  localparam int              QW       = $clog2(QDEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   jump_addr_EXIF,
  input  logic               pc_sel_EXIF,
  input  logic [WIDTH-1:0]   instr_in,
  input  logic [LOGSIZE+1:0] wr_addr,
  input  logic               wr_en,
  input  logic               ready_IDIF,
  output logic               valid_IFID,
  output logic [WIDTH-1:0]   pc_IFID,
  output logic [WIDTH-1:0]   pc_4_IFID,
  output logic [WIDTH-1:0]   instruction_IFID,
  output logic [QW-1:0]      occupancy
);

  logic [WIDTH-1:0] mem [SIZE];
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] inflight_pc;
  logic             inflight;

  logic             pop;
  logic             issue;
  logic [QW:0]      credit_used;
  logic             q_valid;
  logic [QW-1:0]    q_count;
  fetch_entry_t     q_head;
  fetch_entry_t     push_entry;

  // Word-offset bits are ignored on both the redirect target and write address.
  logic unused_low_bits;
  assign unused_low_bits = ^{jump_addr_EXIF[1:0], wr_addr[1:0]};

  // A redirect hides the head so ID cannot consume a word that is being flushed.
  assign valid_IFID = q_valid && !pc_sel_EXIF;
  assign pop        = valid_IFID && ready_IDIF;
  assign occupancy  = q_count;

  // Credit check: queued + in-flight words after this cycle's pop must leave
  // room, so a returning read can never land in a full queue.
  always_comb begin
    credit_used = {1'b0, q_count} + (QW+1)'(inflight) - (QW+1)'(pop);
    issue       = !pc_sel_EXIF && (credit_used < (QW+1)'(QDEPTH));
  end

  // Head fields fall back to a bubble whenever nothing is presented to ID.
  always_comb begin
    pc_IFID          = '0;
    pc_4_IFID        = '0;
    instruction_IFID = WIDTH'(NOP_INSTR);
    if (valid_IFID) begin
      pc_IFID          = WIDTH'(q_head.pc);
      pc_4_IFID        = WIDTH'(q_head.pc_4);
      instruction_IFID = WIDTH'(q_head.instr);
    end
  end

  // The word read last edge is tagged with the PC that requested it.
  always_comb begin
    push_entry       = '0;
    push_entry.pc    = FETCH_WIDTH'(inflight_pc);
    push_entry.pc_4  = FETCH_WIDTH'(inflight_pc + WIDTH'(4));
    push_entry.instr = FETCH_WIDTH'(rd_data);
  end

  // Synchronous-read memory; the read samples the old word on a same-word write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr[LOGSIZE+1:2]] <= instr_in;
    end
    if (issue) begin
      rd_data <= mem[fetch_pc[LOGSIZE+1:2]];
    end
  end

  // PC sequencing and in-flight tracking; a redirect overrides any issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (pc_sel_EXIF) begin
      fetch_pc <= {jump_addr_EXIF[WIDTH-1:2], 2'b00};
      inflight <= 1'b0;
    end else if (issue) begin
      fetch_pc    <= fetch_pc + WIDTH'(4);
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (pc_sel_EXIF),
    .push      (inflight),
    .push_data (push_entry),
    .pop       (pop),
    .head      (q_head),
    .valid     (q_valid),
    .count     (q_count)
  );

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - self-checking bench for instruction_fetch_queue
module tb_instruction_fetch_queue;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] jump_addr_EXIF = '0;
  logic        pc_sel_EXIF = 1'b0;
  logic [31:0] instr_in = '0;
  logic [9:0]  wr_addr = '0;
  logic        wr_en = 1'b0;
  logic        ready_IDIF = 1'b0;
  logic        valid_IFID;
  logic [31:0] pc_IFID;
  logic [31:0] pc_4_IFID;
  logic [31:0] instruction_IFID;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ment_t;

  ment_t       m_q[$];
  logic [31:0] m_mem[256];
  logic [31:0] m_pc;
  bit          m_infl;
  logic [31:0] m_ipc;
  logic [31:0] m_idata;
  logic [31:0] held_pc;

  instruction_fetch_queue dut (
    .clk              (clk),
    .reset            (reset),
    .jump_addr_EXIF   (jump_addr_EXIF),
    .pc_sel_EXIF      (pc_sel_EXIF),
    .instr_in         (instr_in),
    .wr_addr          (wr_addr),
    .wr_en            (wr_en),
    .ready_IDIF       (ready_IDIF),
    .valid_IFID       (valid_IFID),
    .pc_IFID          (pc_IFID),
    .pc_4_IFID        (pc_4_IFID),
    .instruction_IFID (instruction_IFID),
    .occupancy        (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_infl = 0;
    m_pc   = 32'h0;
  endtask

  // Compare every output against what the model says ID should see now.
  task automatic check_outputs();
    bit v;
    v = (m_q.size() > 0) && !pc_sel_EXIF && reset;
    chk("valid", {31'b0, valid_IFID}, {31'b0, v});
    if (v) begin
      chk("pc", pc_IFID, m_q[0].pc);
      chk("pc_4", pc_4_IFID, m_q[0].pc + 32'd4);
      chk("instr", instruction_IFID, m_q[0].instr);
    end else begin
      chk("pc_idle", pc_IFID, 32'h0);
      chk("pc_4_idle", pc_4_IFID, 32'h0);
      chk("instr_idle", instruction_IFID, 32'h13);
    end
    chk("occupancy", {29'b0, occupancy}, m_q.size());
    checks++;
    assert (occupancy <= 3'(QD)) else begin
      errors++;
      $error("FAIL occ_bound observed=%0d expected<=%0d", occupancy, QD);
    end
  endtask

  // One clock edge of the fetch rules, applied with the inputs now driven.
  task automatic model_edge();
    int occ;
    bit pop;
    bit iss;
    if (!reset) begin
      model_reset();
    end else if (pc_sel_EXIF) begin
      m_q.delete();
      m_infl = 0;
      m_pc   = {jump_addr_EXIF[31:2], 2'b00};
    end else begin
      occ = m_q.size();
      pop = (occ > 0) && ready_IDIF;
      iss = (occ + int'(m_infl) - int'(pop)) < QD;
      if (pop) void'(m_q.pop_front());
      if (m_infl) begin
        checks++;
        assert (m_q.size() < QD) else begin
          errors++;
          $error("FAIL push_full observed=%0d expected<%0d", m_q.size(), QD);
        end
        m_q.push_back('{pc: m_ipc, instr: m_idata});
      end
      if (iss) begin
        m_ipc   = m_pc;
        m_idata = m_mem[m_pc[9:2]];
        m_pc    = m_pc + 32'd4;
        m_infl  = 1;
      end else begin
        m_infl = 0;
      end
    end
    if (wr_en) m_mem[wr_addr[9:2]] = instr_in;
  endtask

  // Inputs are already driven: check, advance model and DUT by one edge.
  task automatic cycle();
    #1 check_outputs();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // Load mem[i] = 0x1000 + i through the write port while held in reset.
    wr_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wr_addr  = 10'(i * 4);
      instr_in = 32'h1000 + 32'(i);
      cycle();
    end
    wr_en = 1'b0;

    // Release with ready high: valid after the second edge, one word per cycle.
    reset      = 1'b1;
    ready_IDIF = 1'b1;
    cycle();
    chk("t1_not_yet", {31'b0, valid_IFID}, 32'd0);
    cycle();
    chk("t1_first_valid", {31'b0, valid_IFID}, 32'd1);
    chk("t1_first_pc", pc_IFID, 32'h0);
    chk("t1_first_instr", instruction_IFID, 32'h1000);
    cycle();
    // Overwrite word 3 on the edge that reads PC 0xC.
    wr_en    = 1'b1;
    wr_addr  = 10'h00C;
    instr_in = 32'hDEAD;
    cycle();
    wr_en = 1'b0;
    cycle();
    chk("t6_old_pc", pc_IFID, 32'hC);
    chk("t6_old_word", instruction_IFID, 32'h1003);
    run(4);

    // Stall ID: queue saturates and the head holds.
    ready_IDIF = 1'b0;
    held_pc = pc_IFID;
    run(10);
    chk("t2_full", {29'b0, occupancy}, 32'd4);
    chk("t2_held", pc_IFID, held_pc);
    ready_IDIF = 1'b1;
    run(10);

    // Redirect with a full queue.
    ready_IDIF = 1'b0;
    run(6);
    pc_sel_EXIF    = 1'b1;
    jump_addr_EXIF = 32'h40;
    cycle();
    pc_sel_EXIF = 1'b0;
    cycle();
    chk("t3_gap", {31'b0, valid_IFID}, 32'd0);
    cycle();
    chk("t3_pc", pc_IFID, 32'h40);
    chk("t3_instr", instruction_IFID, 32'h1010);

    // Misaligned target, then back-to-back redirects.
    ready_IDIF     = 1'b1;
    pc_sel_EXIF    = 1'b1;
    jump_addr_EXIF = 32'h43;
    cycle();
    pc_sel_EXIF = 1'b0;
    run(2);
    chk("t4_aligned", pc_IFID, 32'h40);
    pc_sel_EXIF    = 1'b1;
    jump_addr_EXIF = 32'h40;
    cycle();
    jump_addr_EXIF = 32'h80;
    cycle();
    pc_sel_EXIF = 1'b0;
    run(2);
    chk("t4_last_wins", pc_IFID, 32'h80);
    chk("t4_last_instr", instruction_IFID, 32'h1020);

    // Reset between edges acts immediately.
    run(5);
    #1 reset = 1'b0;
    model_reset();
    #1;
    chk("t5_valid", {31'b0, valid_IFID}, 32'd0);
    chk("t5_pc", pc_IFID, 32'h0);
    chk("t5_instr", instruction_IFID, 32'h13);
    chk("t5_occ", {29'b0, occupancy}, 32'd0);
    @(negedge clk);
    run(2);
    reset = 1'b1;
    run(2);
    chk("t5_restart_pc", pc_IFID, 32'h0);
    chk("t5_restart_instr", instruction_IFID, 32'h1000);

    // Word 3 now reads back the new data.
    pc_sel_EXIF    = 1'b1;
    jump_addr_EXIF = 32'hC;
    cycle();
    pc_sel_EXIF = 1'b0;
    run(2);
    chk("t6_new_word", instruction_IFID, 32'hDEAD);

    // Memory index aliasing past SIZE words.
    pc_sel_EXIF    = 1'b1;
    jump_addr_EXIF = 32'h3F8;
    cycle();
    pc_sel_EXIF = 1'b0;
    run(4);
    chk("t6_wrap_pc", pc_IFID, 32'h400);
    chk("t6_wrap_instr", instruction_IFID, 32'h1000);

    // PC wraps modulo 2^32.
    pc_sel_EXIF    = 1'b1;
    jump_addr_EXIF = 32'hFFFF_FFFC;
    cycle();
    pc_sel_EXIF = 1'b0;
    run(2);
    chk("pc_top_pc4", pc_4_IFID, 32'h0);
    cycle();
    chk("pc_wrap_pc", pc_IFID, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      ready_IDIF     = ($urandom_range(0, 3) != 0);
      pc_sel_EXIF    = ($urandom_range(0, 15) == 0);
      jump_addr_EXIF = $urandom;
      wr_en          = ($urandom_range(0, 7) == 0);
      wr_addr        = 10'($urandom);
      instr_in       = $urandom;
      cycle();
    end
    pc_sel_EXIF = 1'b0;
    wr_en       = 1'b0;
    run(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
